irrigation_zone_ctrl: RTL and testbench

Multi-zone successor to the single-valve irrigation FSM. It monitors NUM_ZONES moisture channels and one light channel, and detects dawn as a rising crossing of a light threshold. It runs one valve at a time, because there is a single shared pump, and grants zones round-robin. Two watering durations apply: long for severe drought at any time, short for mild drought during the dawn window only.

---
 rtl/irrigation_zone_ctrl.sv | 160 ++++++++++++++++
 tb/tb_irrigation_zone_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/irrigation_zone_ctrl.sv
// Multi-zone irrigation controller: dawn detection on a rising light crossing,
// round-robin grant of one valve at a time, long/short watering durations.
module irrigation_zone_ctrl #(
  parameter int unsigned NUM_ZONES  = 4,
  parameter int unsigned M_WIDTH    = 8,
  parameter int unsigned L_WIDTH    = 8,
  parameter int unsigned T_WIDTH    = 8,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_ZONES*M_WIDTH-1:0] m_sense,
  input  logic [L_WIDTH-1:0]           l_sense,
  input  logic [M_WIDTH-1:0]           m_thresh_1,
  input  logic [M_WIDTH-1:0]           m_thresh_2,
  input  logic [L_WIDTH-1:0]           l_thresh,
  input  logic [T_WIDTH-1:0]           water_time_short,
  input  logic [T_WIDTH-1:0]           water_time_long,
  input  logic [T_WIDTH-1:0]           dawn_timebox,
  input  logic [NUM_ZONES-1:0]         zone_en,
  output logic [NUM_ZONES-1:0]         water_toggle,
  output logic [$clog2(NUM_ZONES)-1:0] active_zone,
  output logic                         busy,
  output logic                         dawn_active
);

  localparam int unsigned Z_WIDTH = $clog2(NUM_ZONES);
  localparam logic [T_WIDTH-1:0] GAP_LAST = T_WIDTH'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {STANDBY, DAWN, WATER, GAP} state_t;

  state_t               state;
  logic [L_WIDTH-1:0]   light_prev;
  logic [T_WIDTH-1:0]   dawn_cnt;
  logic [T_WIDTH-1:0]   water_cnt;
  logic [T_WIDTH-1:0]   gap_cnt;
  logic [T_WIDTH-1:0]   dur;
  logic [Z_WIDTH-1:0]   rr_ptr;
  logic [NUM_ZONES-1:0] served_mask;

  logic                 dawn_edge;
  logic                 dawn_close;
  logic                 dawn_over;
  logic                 grant;
  logic [T_WIDTH:0]     dawn_cnt_inc;
  logic [NUM_ZONES-1:0] sev;
  logic [NUM_ZONES-1:0] mild;
  logic [NUM_ZONES-1:0] req;
  logic [NUM_ZONES-1:0] winner_oh;
  logic [Z_WIDTH-1:0]   winner;
  logic [Z_WIDTH-1:0]   rr_next;

  // Dawn edge and window bookkeeping
  always_comb begin
    dawn_edge    = (l_sense >= l_thresh) && !(light_prev >= l_thresh);
    dawn_cnt_inc = {1'b0, dawn_cnt} + (T_WIDTH+1)'(1);
    dawn_close   = dawn_active && (dawn_cnt_inc >= {1'b0, dawn_timebox});
    dawn_over    = !dawn_edge && (!dawn_active || dawn_close);
  end

  // Per-zone severe / mild requests
  always_comb begin
    sev  = '0;
    mild = '0;
    for (int unsigned i = 0; i < NUM_ZONES; i++) begin
      sev[i]  = zone_en[i] && (m_sense[i*M_WIDTH +: M_WIDTH] < m_thresh_2);
      mild[i] = zone_en[i] && (m_sense[i*M_WIDTH +: M_WIDTH] < m_thresh_1) &&
                dawn_active && !served_mask[i];
    end
    req = sev | mild;
  end

  // Round-robin search starting at rr_ptr, wrapping around
  always_comb begin : arb
    int unsigned idx;
    logic        found;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int unsigned k = 0; k < NUM_ZONES; k++) begin
      idx = (32'(rr_ptr) + k) % NUM_ZONES;
      if (!found && req[Z_WIDTH'(idx)]) begin
        found  = 1'b1;
        winner = Z_WIDTH'(idx);
      end
    end
    winner_oh         = '0;
    winner_oh[winner] = 1'b1;
    rr_next           = Z_WIDTH'((32'(winner) + 1) % NUM_ZONES);
    grant             = (|req) && (((state == STANDBY) && !dawn_edge) || (state == DAWN));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= STANDBY;
      water_toggle <= '0;
      active_zone  <= '0;
      busy         <= 1'b0;
      dawn_active  <= 1'b0;
      rr_ptr       <= '0;
      served_mask  <= '0;
      dawn_cnt     <= '0;
      water_cnt    <= '0;
      gap_cnt      <= '0;
      dur          <= '0;
      // All-ones so a light level already above threshold is not a dawn edge
      light_prev   <= '1;
    end else begin
      light_prev <= l_sense;

      if (dawn_edge) begin
        dawn_cnt    <= '0;
        dawn_active <= 1'b1;
      end else if (dawn_active) begin
        if (dawn_cnt != '1) dawn_cnt <= dawn_cnt + T_WIDTH'(1);
        if (dawn_close) dawn_active <= 1'b0;
      end

      // A grant on the dawn edge still counts as served in the new window
      served_mask <= (served_mask & {NUM_ZONES{!dawn_edge}}) | (winner_oh & {NUM_ZONES{grant}});

      if (grant) begin
        state        <= WATER;
        active_zone  <= winner;
        water_toggle <= winner_oh;
        busy         <= 1'b1;
        dur          <= sev[winner] ? water_time_long : water_time_short;
        water_cnt    <= T_WIDTH'(1);
        rr_ptr       <= rr_next;
      end else begin
        case (state)
          STANDBY: begin
            if (dawn_edge) state <= DAWN;
          end
          DAWN: begin
            if (dawn_over) state <= STANDBY;
          end
          WATER: begin
            water_cnt <= water_cnt + T_WIDTH'(1);
            if ((water_cnt >= dur) || !zone_en[active_zone]) begin
              water_toggle <= '0;
              gap_cnt      <= '0;
              state        <= GAP;
            end
          end
          GAP: begin
            gap_cnt <= gap_cnt + T_WIDTH'(1);
            if (gap_cnt >= GAP_LAST) begin
              busy        <= 1'b0;
              active_zone <= '0;
              state       <= (dawn_active || dawn_edge) ? DAWN : STANDBY;
            end
          end
          default: state <= STANDBY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_irrigation_zone_ctrl.sv
// Directed self-checking bench for irrigation_zone_ctrl; inputs change and
// outputs are sampled on the falling clock edge.
module tb_irrigation_zone_ctrl;

  localparam int unsigned NZ = 4;

  logic          clk;
  logic          rst;
  logic [NZ*8-1:0] m_sense;
  logic [7:0]    l_sense;
  logic [7:0]    m_thresh_1;
  logic [7:0]    m_thresh_2;
  logic [7:0]    l_thresh;
  logic [7:0]    water_time_short;
  logic [7:0]    water_time_long;
  logic [7:0]    dawn_timebox;
  logic [NZ-1:0] zone_en;
  logic [NZ-1:0] water_toggle;
  logic [1:0]    active_zone;
  logic          busy;
  logic          dawn_active;

  int checks = 0;
  int errors = 0;

  irrigation_zone_ctrl #(
    .NUM_ZONES(4), .M_WIDTH(8), .L_WIDTH(8), .T_WIDTH(8), .GAP_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .m_sense(m_sense), .l_sense(l_sense),
    .m_thresh_1(m_thresh_1), .m_thresh_2(m_thresh_2), .l_thresh(l_thresh),
    .water_time_short(water_time_short), .water_time_long(water_time_long),
    .dawn_timebox(dawn_timebox), .zone_en(zone_en),
    .water_toggle(water_toggle), .active_zone(active_zone),
    .busy(busy), .dawn_active(dawn_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_m(input int z, input logic [7:0] v);
    m_sense[z*8 +: 8] = v;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    m_sense = {NZ{8'd200}};
    l_sense = 8'd10;
    m_thresh_1 = 8'd100;
    m_thresh_2 = 8'd50;
    l_thresh = 8'd100;
    water_time_short = 8'd5;
    water_time_long = 8'd10;
    dawn_timebox = 8'd30;
    zone_en = 4'hF;

    // reset state
    tick(2);
    check("rst_toggle", 32'(water_toggle), 0);
    check("rst_zone", 32'(active_zone), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_dawn", 32'(dawn_active), 0);
    rst = 1'b0;

    // all wet, dark: nothing happens
    for (int i = 0; i < 50; i++) begin
      tick(1);
      check("idle_toggle", 32'(water_toggle), 0);
      check("idle_busy", 32'(busy), 0);
      check("idle_dawn", 32'(dawn_active), 0);
    end

    // dawn with zones 0 and 3 mildly dry
    l_sense = 8'd120;
    set_m(0, 8'd80);
    set_m(3, 8'd80);
    tick(1);
    check("dawn_edge_active", 32'(dawn_active), 1);
    check("dawn_edge_toggle", 32'(water_toggle), 0);
    tick(1);
    check("dawn_z0_toggle", 32'(water_toggle), 32'h1);
    check("dawn_z0_zone", 32'(active_zone), 0);
    check("dawn_z0_busy", 32'(busy), 1);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("dawn_z0_hold", 32'(water_toggle), 32'h1);
    end
    tick(1);
    check("dawn_z0_close", 32'(water_toggle), 0);
    check("dawn_z0_gap_busy", 32'(busy), 1);
    tick(4);
    check("dawn_gap_end_busy", 32'(busy), 0);
    check("dawn_gap_end_zone", 32'(active_zone), 0);
    check("dawn_gap_end_active", 32'(dawn_active), 1);
    tick(1);
    check("dawn_z3_toggle", 32'(water_toggle), 32'h8);
    check("dawn_z3_zone", 32'(active_zone), 3);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("dawn_z3_hold", 32'(water_toggle), 32'h8);
    end
    tick(1);
    check("dawn_z3_close", 32'(water_toggle), 0);
    for (int i = 0; i < 13; i++) begin
      tick(1);
      check("dawn_no_regrant", 32'(water_toggle), 0);
      check("dawn_window_open", 32'(dawn_active), 1);
    end
    tick(1);
    check("dawn_window_closed", 32'(dawn_active), 0);
    set_m(0, 8'd200);
    set_m(3, 8'd200);

    // zone 2 severe, long duration, re-granted after the gap
    set_m(2, 8'd40);
    tick(1);
    check("sev_z2_toggle", 32'(water_toggle), 32'h4);
    check("sev_z2_zone", 32'(active_zone), 2);
    check("sev_z2_busy", 32'(busy), 1);
    for (int i = 0; i < 9; i++) begin
      tick(1);
      check("sev_z2_hold", 32'(water_toggle), 32'h4);
    end
    tick(1);
    check("sev_z2_close", 32'(water_toggle), 0);
    check("sev_z2_gap_zone", 32'(active_zone), 2);
    check("sev_z2_gap_busy", 32'(busy), 1);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("sev_gap_busy", 32'(busy), 1);
      check("sev_gap_toggle", 32'(water_toggle), 0);
    end
    tick(1);
    check("sev_standby_busy", 32'(busy), 0);
    check("sev_standby_zone", 32'(active_zone), 0);
    check("sev_standby_toggle", 32'(water_toggle), 0);
    tick(1);
    check("sev_regrant", 32'(water_toggle), 32'h4);
    set_m(2, 8'd200);
    tick(20);
    check("sev_done_toggle", 32'(water_toggle), 0);
    check("sev_done_busy", 32'(busy), 0);

    // zone 0 aborted by dropping its enable
    water_time_long = 8'd20;
    set_m(0, 8'd40);
    tick(1);
    check("abort_grant", 32'(water_toggle), 32'h1);
    check("abort_grant_busy", 32'(busy), 1);
    tick(4);
    check("abort_pre", 32'(water_toggle), 32'h1);
    zone_en = 4'b1110;
    tick(1);
    check("abort_close", 32'(water_toggle), 0);
    check("abort_gap_busy", 32'(busy), 1);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("abort_gap_hold", 32'(busy), 1);
    end
    tick(1);
    check("abort_gap_end", 32'(busy), 0);
    set_m(0, 8'd200);
    zone_en = 4'hF;
    water_time_long = 8'd10;

    // round robin: zone 1 alone, then zones 1 and 2 both severe with rr_ptr=2
    set_m(1, 8'd40);
    tick(1);
    check("rr_z1_first", 32'(water_toggle), 32'h2);
    set_m(2, 8'd40);
    for (int i = 0; i < 9; i++) begin
      tick(1);
      check("rr_z1_hold", 32'(water_toggle), 32'h2);
    end
    tick(1);
    check("rr_z1_close", 32'(water_toggle), 0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("rr_gap_toggle", 32'(water_toggle), 0);
    end
    tick(1);
    check("rr_standby_busy", 32'(busy), 0);
    tick(1);
    check("rr_z2_wins", 32'(water_toggle), 32'h4);
    check("rr_z2_zone", 32'(active_zone), 2);
    set_m(2, 8'd200);
    for (int i = 0; i < 9; i++) begin
      tick(1);
      check("rr_z2_hold", 32'(water_toggle), 32'h4);
    end
    tick(1);
    check("rr_z2_close", 32'(water_toggle), 0);
    tick(4);
    check("rr_gap2_end", 32'(busy), 0);
    tick(1);
    check("rr_z1_again", 32'(water_toggle), 32'h2);
    check("rr_z1_again_zone", 32'(active_zone), 1);
    set_m(1, 8'd200);

    // reset mid-watering, light already above threshold afterwards
    tick(2);
    check("rstw_pre", 32'(water_toggle), 32'h2);
    rst = 1'b1;
    tick(1);
    check("rstw_toggle", 32'(water_toggle), 0);
    check("rstw_zone", 32'(active_zone), 0);
    check("rstw_busy", 32'(busy), 0);
    check("rstw_dawn", 32'(dawn_active), 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("post_rst_no_dawn", 32'(dawn_active), 0);
      check("post_rst_toggle", 32'(water_toggle), 0);
      check("post_rst_busy", 32'(busy), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
